mov_sequencer: RTL and testbench
================================

Name: mov_sequencer

Overview:
- Parametrised two-instruction register-move decoder.
- A MOV1 word names the destination register; a later MOV2 word names the source. On the MOV2 the block issues one registered write-enable with destination and source selects to the register file.
- Adds over the earlier MOV decoder: configurable instruction and register-address widths, an explicit pending state with a stall-tolerant timeout, orphan-MOV2 error reporting, optional self-move suppression, and registered outputs.

Parameters:
- INSTR_W, 8, instruction width; must be >= 4 + REG_ADDR_W.
- REG_ADDR_W, 3, register select width (2**REG_ADDR_W registers).
- TIMEOUT, 4, maximum consecutive stall cycles tolerated while pending (1..255).
- SUPPRESS_SELF, 1, when 1, a MOV with src == dst issues no write.

Ports:
- clk  in  1  system clock, all logic rising-edge.
- rst  in  1  synchronous, active-high reset.
- enabled  in  1  decode enable; low freezes all state.
- instruction  in  INSTR_W  current instruction word.
- write_enable  out  1  registered one-cycle register-file write strobe.
- write_select  out  REG_ADDR_W  destination register, valid with write_enable.
- read_select  out  REG_ADDR_W  source register, valid with write_enable.
- pending  out  1  high while a MOV1 awaits its MOV2.
- timeout_pulse  out  1  one-cycle pulse when a pending MOV is dropped by timeout.
- orphan_err  out  1  one-cycle pulse when a MOV2 arrives with nothing pending.

Behaviour:
- Clock and reset: one clock, clk; reset rst is synchronous and active-high. While rst is high at a clock edge, every output is set to 0, the state goes to IDLE, and the stall counter and dest register clear. Reset wins over all other inputs, including mid-sequence.
- Instruction decode:
  - opcode = instruction[INSTR_W-1 -: 4]
  - reg field = instruction[INSTR_W-5 -: REG_ADDR_W]
  - MOV1 = 4'b1110; MOV2 = 4'b1111
  - STALL = all-ones word. STALL takes priority over the MOV2 decode.
- States: IDLE, PENDING.
- IDLE:
  - MOV1 -> capture the reg field into dest, clear the counter, go to PENDING.
  - MOV2 (non-STALL) -> orphan_err pulses on the next cycle; stay in IDLE.
  - Any other word -> no action.
- PENDING:
  - MOV2 -> issue the write, go to IDLE. Next cycle: write_enable = 1, write_select = dest, read_select = MOV2 reg field. If SUPPRESS_SELF = 1 and the two fields are equal, write_enable stays 0 but the state still returns to IDLE.
  - MOV1 -> overwrite dest, clear the counter, stay in PENDING.
  - STALL -> increment the counter. If the counter reaches TIMEOUT (checked before the increment), go to IDLE instead, and timeout_pulse pulses on the next cycle.
  - Any other word -> abort silently to IDLE; no pulse.
- pending = (state == PENDING), registered.
- enabled low: no state, counter or dest change. write_enable, timeout_pulse and orphan_err are 0 on the next cycle; the selects hold their last value.
- write_select and read_select are 0 whenever write_enable is 0, except while enabled is low (held).
- Latency: exactly 1 cycle from the MOV2 edge to write_enable. Back-to-back MOV1, MOV2, MOV1, MOV2 produces a write on every second cycle with no bubble.
- Counter width is clog2(TIMEOUT+1); it saturates and never wraps.

Decomposition:
- Shared package mov_pkg holds:
  - opcode localparams OP_MOV1 and OP_MOV2
  - a STALL-word function parametrised by INSTR_W
  - a state enum {IDLE, PENDING}
- Natural sub-module: mov_decode, purely combinational. It classifies a word into is_mov1, is_mov2, is_stall and extracts the reg field. The top level holds the FSM, counter and output registers.

Test Plan:
- All cases use INSTR_W = 8, REG_ADDR_W = 3, TIMEOUT = 4, SUPPRESS_SELF = 1.
- Basic move: rst high then released, enabled = 1, send 0xEA (MOV1 dst 5) then 0xF4 (MOV2 src 2) -> the cycle after 0xF4: write_enable = 1, write_select = 5, read_select = 2, pending = 0.
- Stall tolerance and timeout: 0xEA, then 0xFF for 3 cycles, then 0xF4 -> write with sel 5/2. Repeat with 5 stalls -> timeout_pulse on the cycle after the 5th stall; a following 0xF4 then raises orphan_err and no write.
- Re-target: 0xEA, 0xE6 (MOV1 dst 3), 0xF2 (src 1) -> single write, write_select = 3, read_select = 1.
- Self-move suppression: 0xEA, 0xFA (src 5) -> write_enable stays 0, pending drops to 0, no error pulse.
- Abort and freeze: 0xEA, 0x12 -> pending = 0, no pulses. Separately: 0xEA, then enabled = 0 for 10 cycles with 0xFF applied, then enabled = 1 with 0xF4 -> write 5/2 and no timeout.
- Reset mid-sequence: 0xEA, rst high for one edge, then 0xF4 -> all outputs 0 after reset; orphan_err = 1 the cycle after 0xF4.

Source files
------------

// File: rtl/mov_pkg.sv
// rtl/mov_pkg.sv - shared opcodes, STALL word helper and FSM state type for the MOV sequencer
package mov_pkg;

  localparam logic [3:0] OP_MOV1 = 4'b1110;
  localparam logic [3:0] OP_MOV2 = 4'b1111;

  // Widest instruction word the STALL helper can describe.
  localparam int MAX_INSTR_W = 64;

  typedef enum logic {
    IDLE    = 1'b0,
    PENDING = 1'b1
  } state_t;

  // All-ones word of the given width, right-aligned in a MAX_INSTR_W container.
  function automatic logic [MAX_INSTR_W-1:0] stall_word(input int width);
    logic [MAX_INSTR_W-1:0] ones;
    ones = '1;
    return ones >> (MAX_INSTR_W - width);
  endfunction

endpackage

// File: rtl/mov_decode.sv
// rtl/mov_decode.sv - combinational classifier for MOV1 / MOV2 / STALL words and reg-field extraction
module mov_decode
  import mov_pkg::*;
#(
  parameter int INSTR_W    = 8,
  parameter int REG_ADDR_W = 3
) (
  input  logic [INSTR_W-1:0]    instruction,
  output logic                  is_mov1,
  output logic                  is_mov2,
  output logic                  is_stall,
  output logic [REG_ADDR_W-1:0] reg_field
);

  localparam logic [MAX_INSTR_W-1:0] STALL_FULL = stall_word(INSTR_W);
  localparam logic [INSTR_W-1:0]     STALL      = STALL_FULL[INSTR_W-1:0];

  logic [3:0] opcode;

  assign opcode    = instruction[INSTR_W-1 -: 4];
  assign reg_field = instruction[INSTR_W-5 -: REG_ADDR_W];
  assign is_stall  = (instruction == STALL);

  // STALL shares the MOV2 opcode, so it must mask the MOV2 classification.
  assign is_mov1 = (opcode == OP_MOV1) && !is_stall;
  assign is_mov2 = (opcode == OP_MOV2) && !is_stall;

endmodule

// File: rtl/mov_sequencer.sv
// rtl/mov_sequencer.sv - two-word register-move sequencer: MOV1 names dest, MOV2 names source and fires the write
module mov_sequencer
  import mov_pkg::*;
#(
  parameter int INSTR_W       = 8,
  parameter int REG_ADDR_W    = 3,
  parameter int TIMEOUT       = 4,
  parameter int SUPPRESS_SELF = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  enabled,
  input  logic [INSTR_W-1:0]    instruction,
  output logic                  write_enable,
  output logic [REG_ADDR_W-1:0] write_select,
  output logic [REG_ADDR_W-1:0] read_select,
  output logic                  pending,
  output logic                  timeout_pulse,
  output logic                  orphan_err
);

  localparam int               CNT_W       = $clog2(TIMEOUT + 1);
  localparam logic [CNT_W-1:0] TIMEOUT_CNT = CNT_W'(TIMEOUT);
  localparam logic             SUPPRESS    = (SUPPRESS_SELF != 0);

  logic                  is_mov1;
  logic                  is_mov2;
  logic                  is_stall;
  logic [REG_ADDR_W-1:0] reg_field;

  state_t                state;
  logic [CNT_W-1:0]      stall_cnt;
  logic [REG_ADDR_W-1:0] dest;

  mov_decode #(
    .INSTR_W    (INSTR_W),
    .REG_ADDR_W (REG_ADDR_W)
  ) u_decode (
    .instruction (instruction),
    .is_mov1     (is_mov1),
    .is_mov2     (is_mov2),
    .is_stall    (is_stall),
    .reg_field   (reg_field)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= IDLE;
      stall_cnt     <= '0;
      dest          <= '0;
      write_enable  <= 1'b0;
      write_select  <= '0;
      read_select   <= '0;
      pending       <= 1'b0;
      timeout_pulse <= 1'b0;
      orphan_err    <= 1'b0;
    end else if (!enabled) begin
      // Frozen: state, counter, dest, pending and selects hold; strobes drop.
      write_enable  <= 1'b0;
      timeout_pulse <= 1'b0;
      orphan_err    <= 1'b0;
    end else begin
      write_enable  <= 1'b0;
      write_select  <= '0;
      read_select   <= '0;
      timeout_pulse <= 1'b0;
      orphan_err    <= 1'b0;

      case (state)
        IDLE: begin
          if (is_mov1) begin
            dest      <= reg_field;
            stall_cnt <= '0;
            state     <= PENDING;
            pending   <= 1'b1;
          end else if (is_mov2) begin
            orphan_err <= 1'b1;
          end
        end

        PENDING: begin
          if (is_stall) begin
            // Counter never passes TIMEOUT: reaching it drops the move instead.
            if (stall_cnt == TIMEOUT_CNT) begin
              state         <= IDLE;
              pending       <= 1'b0;
              stall_cnt     <= '0;
              timeout_pulse <= 1'b1;
            end else begin
              stall_cnt <= stall_cnt + 1'b1;
            end
          end else if (is_mov2) begin
            state   <= IDLE;
            pending <= 1'b0;
            if (!(SUPPRESS && (reg_field == dest))) begin
              write_enable <= 1'b1;
              write_select <= dest;
              read_select  <= reg_field;
            end
          end else if (is_mov1) begin
            dest      <= reg_field;
            stall_cnt <= '0;
          end else begin
            state   <= IDLE;
            pending <= 1'b0;
          end
        end

        default: begin
          state   <= IDLE;
          pending <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mov_sequencer.sv
// tb/tb_mov_sequencer.sv - directed and randomized bench for mov_sequencer against a behavioural model
module tb_mov_sequencer;

  localparam int INSTR_W    = 8;
  localparam int REG_ADDR_W = 3;
  localparam int TIMEOUT    = 4;

  logic                  clk = 1'b0;
  logic                  rst;
  logic                  enabled;
  logic [INSTR_W-1:0]    instruction;
  logic                  write_enable;
  logic [REG_ADDR_W-1:0] write_select;
  logic [REG_ADDR_W-1:0] read_select;
  logic                  pending;
  logic                  timeout_pulse;
  logic                  orphan_err;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model: a remembered destination, a count of stalls seen since it was named.
  bit m_pend   = 0;
  int m_dst    = 0;
  int m_stalls = 0;
  int e_we = 0, e_ws = 0, e_rs = 0, e_tp = 0, e_oe = 0;

  mov_sequencer #(
    .INSTR_W       (INSTR_W),
    .REG_ADDR_W    (REG_ADDR_W),
    .TIMEOUT       (TIMEOUT),
    .SUPPRESS_SELF (1)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .enabled       (enabled),
    .instruction   (instruction),
    .write_enable  (write_enable),
    .write_select  (write_select),
    .read_select   (read_select),
    .pending       (pending),
    .timeout_pulse (timeout_pulse),
    .orphan_err    (orphan_err)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input int obs, input int exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic int dut_vec();
    return int'({write_enable, write_select, read_select, pending, timeout_pulse, orphan_err});
  endfunction

  function automatic int exp_vec();
    return (e_we << 9) | (e_ws << 6) | (e_rs << 3) | (int'(m_pend) << 2) | (e_tp << 1) | e_oe;
  endfunction

  task automatic model(input bit r, input bit en, input int ins);
    int op, fld;
    bit stall;
    op    = ins / 16;
    fld   = (ins / 2) % 8;
    stall = (ins == 255);
    if (r) begin
      m_pend = 0; m_dst = 0; m_stalls = 0;
      e_we = 0; e_ws = 0; e_rs = 0; e_tp = 0; e_oe = 0;
    end else if (!en) begin
      e_we = 0; e_tp = 0; e_oe = 0;
    end else begin
      e_we = 0; e_ws = 0; e_rs = 0; e_tp = 0; e_oe = 0;
      if (!m_pend) begin
        if (!stall && op == 14) begin
          m_pend = 1; m_dst = fld; m_stalls = 0;
        end else if (!stall && op == 15) begin
          e_oe = 1;
        end
      end else if (stall) begin
        m_stalls++;
        if (m_stalls > TIMEOUT) begin
          m_pend = 0; e_tp = 1;
        end
      end else if (op == 15) begin
        m_pend = 0;
        if (fld != m_dst) begin
          e_we = 1; e_ws = m_dst; e_rs = fld;
        end
      end else if (op == 14) begin
        m_dst = fld; m_stalls = 0;
      end else begin
        m_pend = 0;
      end
    end
  endtask

  task automatic step(input bit r, input bit en, input logic [7:0] ins, input string tag);
    rst = r; enabled = en; instruction = ins;
    @(posedge clk);
    model(r, en, int'(ins));
    #1;
    check(tag, dut_vec(), exp_vec());
  endtask

  initial begin
    logic [7:0] ins;
    int         k;
    rst = 1'b1; enabled = 1'b0; instruction = '0;

    step(1, 1, 8'h00, "reset0");
    step(1, 1, 8'hEA, "reset1");
    check("reset_outputs", dut_vec(), 0);

    step(0, 1, 8'hEA, "basic_mov1");
    check("basic_pending", pending, 1);
    step(0, 1, 8'hF4, "basic_mov2");
    check("basic_we", write_enable, 1);
    check("basic_ws", write_select, 5);
    check("basic_rs", read_select, 2);
    check("basic_pend", pending, 0);

    step(0, 1, 8'hEA, "stall3_mov1");
    for (int i = 0; i < 3; i++) step(0, 1, 8'hFF, "stall3_ff");
    step(0, 1, 8'hF4, "stall3_mov2");
    check("stall3_write", {write_enable, write_select, read_select}, {1'b1, 3'd5, 3'd2});

    step(0, 1, 8'hEA, "stall5_mov1");
    for (int i = 0; i < 4; i++) step(0, 1, 8'hFF, "stall5_ff");
    check("stall4_no_timeout", {timeout_pulse, pending}, 2'b01);
    step(0, 1, 8'hFF, "stall5_last");
    check("stall5_timeout", {timeout_pulse, pending}, 2'b10);
    step(0, 1, 8'hF4, "stall5_orphan");
    check("stall5_orphan_err", orphan_err, 1);
    check("stall5_no_write", write_enable, 0);

    step(0, 1, 8'hEA, "retarget_a");
    step(0, 1, 8'hE6, "retarget_b");
    step(0, 1, 8'hF2, "retarget_c");
    check("retarget_write", {write_enable, write_select, read_select}, {1'b1, 3'd3, 3'd1});

    step(0, 1, 8'hEA, "self_a");
    step(0, 1, 8'hFA, "self_b");
    check("self_quiet", {write_enable, pending, timeout_pulse, orphan_err}, 4'b0000);

    step(0, 1, 8'hEA, "abort_a");
    step(0, 1, 8'h12, "abort_b");
    check("abort_quiet", {pending, timeout_pulse, orphan_err}, 3'b000);

    step(0, 1, 8'hEA, "freeze_a");
    for (int i = 0; i < 10; i++) step(0, 0, 8'hFF, "freeze_hold");
    check("freeze_pending", pending, 1);
    step(0, 1, 8'hF4, "freeze_mov2");
    check("freeze_write", {write_enable, write_select, read_select, timeout_pulse}, {1'b1, 3'd5, 3'd2, 1'b0});

    step(0, 1, 8'hEA, "midrst_a");
    step(1, 1, 8'hF4, "midrst_rst");
    check("midrst_zero", dut_vec(), 0);
    step(0, 1, 8'hF4, "midrst_mov2");
    check("midrst_orphan", orphan_err, 1);

    for (int i = 0; i < 3000; i++) begin
      k = int'($urandom_range(0, 9));
      case (k)
        0, 1, 2: ins = 8'hFF;
        3, 4:    ins = {4'hE, 4'($urandom_range(0, 15))};
        5, 6:    ins = {4'hF, 3'($urandom_range(0, 7)), 1'b0};
        default: ins = 8'($urandom_range(0, 255));
      endcase
      step(($urandom_range(0, 99) < 2), ($urandom_range(0, 99) < 90), ins, "random");
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
